// File: rtl/harris_out_drain.sv
// Captures one frame of Harris kernel writes into a word buffer, then drains it
// in address order over a valid/ready stream with a one-word skid stage.
module harris_out_drain #(
  parameter int WIDTH  = 32,
  parameter int SIZE   = 1024,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              t,
  input  logic [ADDR_W:0]   frame_len,
  input  logic [ADDR_W-1:0] harris_p1_addr_data,
  input  logic              harris_p1_addr_en,
  input  logic [WIDTH-1:0]  harris_p1_wr_data,
  input  logic              harris_p1_wr_en,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  out_data,
  output logic [ADDR_W-1:0] out_addr,
  output logic              out_last,
  output logic              busy,
  output logic              done,
  output logic              err_range,
  output logic              err_dup,
  output logic              err_late
);
  typedef enum logic [1:0] {IDLE, CAPTURE, DRAIN} state_t;

  localparam logic [ADDR_W:0] SIZE_L = (ADDR_W+1)'(SIZE);

  logic unused_addr_en;
  assign unused_addr_en = harris_p1_addr_en;

  // Async assert, two-flop synchronised release; everything else resets from rst_n.
  logic rst_s1_q, rst_s2_q, rst_n;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) {rst_s2_q, rst_s1_q} <= 2'b00;
    else      {rst_s2_q, rst_s1_q} <= {rst_s1_q, 1'b1};
  end
  assign rst_n = rst_s2_q;

  state_t            state_q, state_d;
  logic [ADDR_W:0]   len_q, cnt_q, rd_ptr_q, cnt_inc, flen_eff;
  logic [SIZE-1:0]   bitmap_q;
  logic              err_range_q, err_dup_q, err_late_q, done_q;
  logic              s1_v_q, s1_bit_q, s1_last_q;
  logic [ADDR_W-1:0] s1_addr_q;
  logic              ov_q, ol_q;
  logic [WIDTH-1:0]  od_q;
  logic [ADDR_W-1:0] oa_q;

  logic              wr_hit, in_rng, bit_set, xfer, out_ld, rd_issue;
  logic              ram_en, ram_we;
  logic [ADDR_W-1:0] ram_a;
  logic [WIDTH-1:0]  ram_q;
  logic [WIDTH-1:0]  mem [SIZE];

  assign flen_eff = (frame_len == '0 || frame_len > SIZE_L) ? SIZE_L : frame_len;
  assign wr_hit   = harris_p1_wr_en && (state_q == CAPTURE);
  assign in_rng   = {1'b0, harris_p1_addr_data} < len_q;
  assign bit_set  = bitmap_q[harris_p1_addr_data];
  assign cnt_inc  = cnt_q + 1'b1;
  assign xfer     = ov_q & out_ready;
  assign out_ld   = s1_v_q & (~ov_q | out_ready);
  // A read is issued only when the RAM-output stage is free or being emptied this cycle.
  assign rd_issue = (state_q == DRAIN) && (rd_ptr_q < len_q) && (!s1_v_q || out_ld);
  assign ram_we   = wr_hit & in_rng;
  assign ram_en   = ram_we | rd_issue;
  assign ram_a    = (state_q == CAPTURE) ? harris_p1_addr_data : rd_ptr_q[ADDR_W-1:0];

  // Single-port buffer; read data holds while not enabled, which keeps stalls lossless.
  always_ff @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) mem[ram_a] <= harris_p1_wr_data;
      ram_q <= mem[ram_a];
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (t) state_d = CAPTURE;
      CAPTURE: if (wr_hit && in_rng && !bit_set && cnt_inc == len_q) state_d = DRAIN;
      DRAIN:   if (xfer && ol_q) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      len_q       <= '0;
      cnt_q       <= '0;
      rd_ptr_q    <= '0;
      bitmap_q    <= '0;
      err_range_q <= 1'b0;
      err_dup_q   <= 1'b0;
      err_late_q  <= 1'b0;
      done_q      <= 1'b0;
      s1_v_q      <= 1'b0;
      s1_bit_q    <= 1'b0;
      s1_last_q   <= 1'b0;
      s1_addr_q   <= '0;
      ov_q        <= 1'b0;
      ol_q        <= 1'b0;
      od_q        <= '0;
      oa_q        <= '0;
    end else begin
      state_q <= state_d;
      done_q  <= xfer & ol_q;
      if (state_q == IDLE && t) begin
        len_q       <= flen_eff;
        cnt_q       <= '0;
        rd_ptr_q    <= '0;
        bitmap_q    <= '0;
        err_range_q <= 1'b0;
        err_dup_q   <= 1'b0;
        err_late_q  <= 1'b0;
      end
      if (harris_p1_wr_en && state_q != CAPTURE) err_late_q <= 1'b1;
      if (wr_hit) begin
        if (!in_rng)      err_range_q <= 1'b1;
        else if (bit_set) err_dup_q   <= 1'b1;
        else begin
          bitmap_q[harris_p1_addr_data] <= 1'b1;
          cnt_q <= cnt_inc;
        end
      end
      if (rd_issue) begin
        rd_ptr_q  <= rd_ptr_q + 1'b1;
        s1_addr_q <= rd_ptr_q[ADDR_W-1:0];
        s1_bit_q  <= bitmap_q[rd_ptr_q[ADDR_W-1:0]];
        s1_last_q <= (rd_ptr_q == len_q - 1'b1);
      end
      if (rd_issue)    s1_v_q <= 1'b1;
      else if (out_ld) s1_v_q <= 1'b0;
      if (out_ld) begin
        ov_q <= 1'b1;
        od_q <= s1_bit_q ? ram_q : '0;
        oa_q <= s1_addr_q;
        ol_q <= s1_last_q;
      end else if (xfer) begin
        ov_q <= 1'b0;
        ol_q <= 1'b0;
      end
    end
  end

  assign out_valid = ov_q;
  assign out_data  = od_q;
  assign out_addr  = oa_q;
  assign out_last  = ol_q;
  assign busy      = (state_q == CAPTURE) || (state_q == DRAIN);
  assign done      = done_q;
  assign err_range = err_range_q;
  assign err_dup   = err_dup_q;
  assign err_late  = err_late_q;
endmodule

// File: tb/tb_harris_out_drain.sv
// Bench for harris_out_drain: frame-level reference model feeds a scoreboard
// queue; an independent negedge monitor checks each transferred word.
module tb_harris_out_drain;
  localparam int WIDTH = 32, SIZE = 1024, ADDR_W = 10;

  logic              clk = 0, rst = 1, t = 0;
  logic [ADDR_W:0]   frame_len = '0;
  logic [ADDR_W-1:0] wa = '0;
  logic              wa_en = 0, we = 0;
  logic [WIDTH-1:0]  wd = '0;
  logic              out_valid, out_ready = 1, out_last, busy, done;
  logic [WIDTH-1:0]  out_data;
  logic [ADDR_W-1:0] out_addr;
  logic              err_range, err_dup, err_late;

  always #5 clk = ~clk;

  harris_out_drain #(.WIDTH(WIDTH), .SIZE(SIZE), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .t(t), .frame_len(frame_len),
    .harris_p1_addr_data(wa), .harris_p1_addr_en(wa_en),
    .harris_p1_wr_data(wd), .harris_p1_wr_en(we),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_addr(out_addr), .out_last(out_last), .busy(busy), .done(done),
    .err_range(err_range), .err_dup(err_dup), .err_late(err_late)
  );

  typedef struct packed {
    logic [WIDTH-1:0]  d;
    logic [ADDR_W-1:0] a;
    logic              l;
  } word_t;

  int chk_cnt = 0, pass_cnt = 0, xfer_cnt = 0, rdy_mode = 0;
  word_t exp_q[$];
  int wq_a[$];
  logic [WIDTH-1:0] wq_d[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // 0: always ready, 1: toggle every cycle, 2: random
  initial forever begin
    @(posedge clk); #1;
    case (rdy_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = ~out_ready;
      default: out_ready = 1'($urandom_range(0, 1));
    endcase
  end

  word_t held;
  bit    held_v = 0;
  always @(negedge clk) begin
    word_t cur, e;
    cur = {out_data, out_addr, out_last};
    if (!rst) held_v = 0;
    else begin
      if (held_v) chk("stall_hold", {out_valid, cur}, {1'b1, held});
      held_v = 0;
      if (out_valid) begin
        if (out_ready) begin
          if (exp_q.size() == 0) begin
            chk_cnt++;
            $display("FAIL extra_word: got %0h expected no word", cur);
          end else begin
            e = exp_q.pop_front();
            chk("word", cur, e);
          end
          xfer_cnt++;
        end else begin
          held_v = 1;
          held   = cur;
        end
      end
    end
  end

  task automatic do_frame(input int flen, input bit gaps, input bit t_mid,
                          input bit late_drain, input bit lat_chk, input bit abort);
    int len, cnt, n, lat, base;
    bit wr[SIZE];
    logic [WIDTH-1:0] md[SIZE];
    bit er, ed, el;
    word_t w;
    er = 0; ed = 0; el = 0; cnt = 0; n = 0;
    base = xfer_cnt;
    len = (flen == 0 || flen > SIZE) ? SIZE : flen;
    foreach (wr[i]) wr[i] = 0;
    for (int i = 0; i < wq_a.size() && cnt < len; i++) begin
      n++;
      if (wq_a[i] >= len) er = 1;
      else begin
        if (wr[wq_a[i]]) ed = 1; else cnt++;
        wr[wq_a[i]] = 1;
        md[wq_a[i]] = wq_d[i];
      end
    end
    if (cnt != len) begin
      $display("FAIL model_incomplete: got %0d expected %0d", cnt, len);
      $fatal(1);
    end
    for (int a = 0; a < len; a++) begin
      w.d = wr[a] ? md[a] : '0;
      w.a = ADDR_W'(a);
      w.l = (a == len - 1);
      exp_q.push_back(w);
    end

    @(posedge clk); #1 t = 1; frame_len = (ADDR_W+1)'(flen);
    @(posedge clk); #1 t = 0;
    for (int i = 0; i < n; i++) begin
      if (gaps) while ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
      if (i == n - 1) chk("hold_capture", {busy, out_valid}, 2'b10);
      we = 1; wa = ADDR_W'(wq_a[i]); wd = wq_d[i];
      if (t_mid && i == 1) begin t = 1; frame_len = 2; end
      @(posedge clk); #1 we = 0; t = 0;
    end
    if (late_drain) begin
      we = 1; wa = 0; wd = 32'hDEAD_BEEF;
      @(posedge clk); #1 we = 0;
      el = 1;
    end
    if (lat_chk) begin
      lat = 0;
      while (!out_valid && lat < 10) begin @(negedge clk); lat++; end
      chk("first_valid_latency", lat, 3);
    end
    if (abort) begin
      lat = 0;
      while (xfer_cnt < base + 2 && lat < 200) begin @(posedge clk); #2; lat++; end
      chk("words_before_abort", xfer_cnt - base, 2);
      rst = 0; #1;
      chk("abort_outputs_zero", {out_valid, out_last, busy, done, err_range, err_dup,
                                 err_late, out_data, out_addr}, 0);
      exp_q.delete();
      #23 rst = 1;
      repeat (4) @(posedge clk);
      #1;
      return;
    end
    lat = 0;
    while (lat < 20 * SIZE + 100) begin
      @(negedge clk); lat++;
      if (done) break;
    end
    chk("done_seen", done, 1);
    chk("idle_at_done", busy, 0);
    chk("queue_drained", exp_q.size(), 0);
    chk("err_flags", {err_range, err_dup, err_late}, {er, ed, el});
    @(negedge clk);
    chk("done_one_cycle", {done, busy, out_valid}, 3'b000);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int len, covered;
    bit cov[16];
    rst = 1; #2 rst = 0; #1;
    chk("reset_outputs", {out_valid, out_last, busy, done, err_range, err_dup, err_late,
                          out_data, out_addr}, 0);
    repeat (3) @(posedge clk); #1;
    chk("reset_held", {out_valid, busy, done, err_late}, 0);
    rst = 1;
    repeat (4) @(posedge clk); #1;

    // basic out-of-order frame
    rdy_mode = 0;
    wq_a = '{3, 1, 0, 2};
    wq_d = '{32'hA3, 32'hA1, 32'hA0, 32'hA2};
    do_frame(4, 0, 0, 0, 1, 0);

    // duplicate and out-of-range writes
    rdy_mode = 2;
    wq_a = '{0, 0, 5, 1, 2};
    wq_d = '{32'h1111, 32'h2222, 32'h5555, 32'h3333, 32'h4444};
    do_frame(3, 1, 0, 0, 0, 0);

    // late write in IDLE; earlier flags persist
    @(posedge clk); #1 we = 1; wa = 7; wd = 32'h77;
    @(posedge clk); #1 we = 0;
    @(negedge clk);
    chk("late_idle_flags", {err_range, err_dup, err_late}, 3'b111);
    chk("late_idle_busy", {busy, out_valid}, 2'b00);

    // t during CAPTURE ignored, late write during DRAIN
    rdy_mode = 0;
    wq_a = '{4, 3, 2, 1, 0};
    wq_d = '{32'hB4, 32'hB3, 32'hB2, 32'hB1, 32'hB0};
    do_frame(5, 0, 1, 1, 0, 0);

    // full-size frame with stalls every other cycle
    rdy_mode = 1;
    wq_a.delete(); wq_d.delete();
    for (int i = 0; i < SIZE; i++) begin wq_a.push_back(i); wq_d.push_back($urandom); end
    do_frame(1024, 0, 0, 0, 0, 0);

    // reset mid-DRAIN, then a fresh short frame
    rdy_mode = 0;
    wq_a = '{0, 1, 2, 3};
    wq_d = '{32'hC0, 32'hC1, 32'hC2, 32'hC3};
    do_frame(4, 0, 0, 0, 0, 1);
    wq_a = '{1, 0};
    wq_d = '{32'hD1, 32'hD0};
    do_frame(2, 0, 0, 0, 1, 0);

    // frame_len 0 means full size; includes one duplicate
    rdy_mode = 2;
    wq_a.delete(); wq_d.delete();
    for (int i = 0; i < SIZE - 1; i++) begin wq_a.push_back(i); wq_d.push_back($urandom); end
    wq_a.push_back(5); wq_d.push_back($urandom);
    wq_a.push_back(SIZE - 1); wq_d.push_back($urandom);
    do_frame(0, 0, 0, 0, 0, 0);

    // random small frames
    for (int f = 0; f < 6; f++) begin
      len = $urandom_range(1, 12);
      wq_a.delete(); wq_d.delete();
      foreach (cov[i]) cov[i] = 0;
      covered = 0;
      while (covered < len) begin
        int a;
        a = $urandom_range(0, len + 2);
        wq_a.push_back(a); wq_d.push_back($urandom);
        if (a < len && !cov[a]) begin cov[a] = 1; covered++; end
      end
      do_frame(len, 1, 0, 0, 0, 0);
    end

    repeat (5) @(posedge clk);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule

// File: doc/harris_out_drain.md
HARRIS_OUT_DRAIN -- requirements
Module: harris_out_drain

Interface
REQ-001 Parameter WIDTH, default 32: data word width.
REQ-002 Parameter SIZE, default 1024: frame buffer depth in words.
REQ-003 Parameter ADDR_W, default 10: address width, equal to log2(SIZE).
REQ-004 The ports SHALL be, one per line:
- clk  in  1  sole clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- t  in  1  one-cycle frame start pulse.
- frame_len  in  ADDR_W+1  expected number of words in the frame; sampled when t is accepted.
- harris_p1_addr_data  in  ADDR_W  kernel write address.
- harris_p1_addr_en  in  1  kernel address strobe; informational only, ignored.
- harris_p1_wr_data  in  WIDTH  kernel write data.
- harris_p1_wr_en  in  1  kernel write strobe.
- out_valid  out  1  drain stream word valid.
- out_ready  in  1  drain stream consumer ready.
- out_data  out  WIDTH  drained word.
- out_addr  out  ADDR_W  buffer address of out_data.
- out_last  out  1  marks the final drained word.
- busy  out  1  high in CAPTURE or DRAIN.
- done  out  1  one-cycle pulse after the last word is transferred.
- err_range  out  1  sticky; a write address was >= the latched frame length.
- err_dup  out  1  sticky; the same address was written twice in one frame.
- err_late  out  1  sticky; a write arrived outside CAPTURE.

Function
REQ-005 The FSM SHALL have the states IDLE, CAPTURE and DRAIN.
REQ-006 IDLE->CAPTURE on t=1; on that edge:
- latch len = frame_len, with 0 or values > SIZE treated as SIZE;
- clear the written-bitmap (SIZE bits), the write count and all err_* flags.
REQ-007 t SHALL be ignored in CAPTURE and DRAIN.
REQ-008 In CAPTURE, a write is a cycle with harris_p1_wr_en=1. Its handling SHALL be:
- addr < len and bit clear: store data, set bit, count+1.
- addr < len and bit set: store data (overwrite), set err_dup, count unchanged.
- addr >= len: drop, set err_range.
REQ-009 The edge on which count reaches len SHALL move the state to DRAIN with rd_ptr=0.
REQ-010 wr_en=1 in IDLE or DRAIN SHALL be dropped and SHALL set err_late.
REQ-011 The buffer SHALL be single-port RAM with 1-cycle synchronous read; RAM contents are not reset.
REQ-012 Drained words whose bitmap bit is clear SHALL read as 0.
REQ-013 DRAIN read timing and output order:
- out_valid rises on the second rising edge after entry to DRAIN.
- Words are presented in address order 0..len-1.
- out_last=1 only with out_addr=len-1.
REQ-014 A transfer is out_valid & out_ready on a rising edge; while out_valid=1 and out_ready=0, out_data/out_addr/out_last SHALL hold stable.
REQ-015 With out_ready held at 1, throughput SHALL be one word per cycle after the first (prefetch/skid register required).
REQ-016 On the transfer of the out_last word, the state SHALL go to IDLE, out_valid drop, and done pulse high for exactly the following cycle.
REQ-017 err_* flags SHALL persist through DRAIN and IDLE until the next accepted t or reset.
REQ-018 busy SHALL be combinational from the state (CAPTURE or DRAIN).

Reset
REQ-019 While rst=0, with no clock required, the block SHALL force:
- state=IDLE;
- out_valid, out_last, busy, done, err_range, err_dup, err_late = 0;
- out_data, out_addr, count, rd_ptr = 0;
- bitmap cleared.
REQ-020 Reset asserted mid-CAPTURE or mid-DRAIN SHALL abandon the frame; after release, no stale word is ever presented.
REQ-021 Reset release SHALL be synchronised internally, with the first state change no earlier than the second edge after release.

Verification
REQ-022 t with frame_len=4; writes addr 3,1,0,2 with data A3,A1,A0,A2; out_ready=1 -> words A0,A1,A2,A3 with addr 0..3, out_last on addr 3, done one cycle later, no err flags.
REQ-023 frame_len=1024; all addresses written in order; out_ready toggling 1/0 each cycle -> 1024 words with no loss or duplication, data held stable through stalls.
REQ-024 frame_len=3; writes addr 0,0,5,1,2 -> err_dup=1, err_range=1; drain yields the second addr-0 data, then addr1, addr2.
REQ-025 wr_en pulsed in IDLE and during DRAIN -> err_late=1, drained data unaffected; t during CAPTURE -> ignored, len unchanged.
REQ-026 rst asserted mid-DRAIN after 2 of 4 words -> all outputs 0 immediately; new t with frame_len=2 -> only the new frame's data drained.
REQ-027 frame_len=0 -> treated as 1024; the block stays in CAPTURE until 1024 distinct addresses are written.
